// File: rtl/isa_pkg.sv
// isa_pkg: shared instruction-word layout for the program loader and the
// control-unit decoder. Holds the legal opcodes, the bit position of every
// field, the decoded-field struct, the packing helper, and the loader FSM
// state encoding.
package isa_pkg;

    localparam logic [5:0] OP_SUMA  = 6'b000001;
    localparam logic [5:0] OP_RESTA = 6'b000010;

    // Field positions (LSB of each field) inside the 32-bit word.
    localparam int OPCODE_LSB = 26;
    localparam int RSVD_BIT   = 25;
    localparam int RD_LSB     = 22;
    localparam int R1_LSB     = 19;
    localparam int R2_LSB     = 16;
    localparam int I1_LSB     = 8;
    localparam int I2_LSB     = 0;

    typedef struct packed {
        logic [5:0] opcode;
        logic [2:0] rd;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [7:0] i1;
        logic [7:0] i2;
    } instr_fields_t;

    // Loader FSM states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [31:0] pack_instr(input instr_fields_t f);
        logic [31:0] w;
        w = '0;
        w[OPCODE_LSB +: 6] = f.opcode;
        w[RSVD_BIT]        = 1'b0;   // reserved, always zero
        w[RD_LSB +: 3]     = f.rd;
        w[R1_LSB +: 3]     = f.r1;
        w[R2_LSB +: 3]     = f.r2;
        w[I1_LSB +: 8]     = f.i1;
        w[I2_LSB +: 8]     = f.i2;
        return w;
    endfunction

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return (op == OP_SUMA) || (op == OP_RESTA);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags.
// Ports: push/wdata write side, pop/rdata read side (rdata is the head entry,
// valid whenever !empty), full/empty status. Push and pop may occur in the
// same cycle; a push while full is ignored, a pop while empty is ignored.
// DEPTH must be a power of 2 and at least 2.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit words and writes
// them sequentially into instruction memory, buffering through a small FIFO.
// Ports:
//   start / finish       one-cycle pulses opening (IDLE) / closing (LOAD) a load
//   in_valid / in_ready  field input, in_opcode/in_rd/in_r1/in_r2/in_i1/in_i2
//   wr_valid / wr_ready  memory write, wr_addr / wr_data
//   busy, done           status (done is a one-cycle pulse)
//   err_opcode           sticky: an illegal opcode beat was dropped
//   err_overflow         sticky: input offered after MEM_WORDS words
//   word_count           words written to memory during this load
//   dbg_state            current FSM state (isa_pkg ST_* encoding)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits on ready, and once raised, valid and its payload hold
// until that transfer. in_ready depends only on state and counters.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int MEM_WORDS  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_r1,
    input  logic [2:0]        in_r2,
    input  logic [7:0]        in_i1,
    input  logic [7:0]        in_i2,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_opcode,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   pushed_q, pushed_d;
    logic              err_op_q, err_op_d;
    logic              err_ov_q, err_ov_d;

    logic              fifo_full, fifo_empty;
    logic [31:0]       fifo_rdata, packed_word;
    logic              below_limit, accept, legal, push, pop;
    instr_fields_t     fields;

    assign fields      = {in_opcode, in_rd, in_r1, in_r2, in_i1, in_i2};
    assign packed_word = pack_instr(fields);
    assign legal       = is_legal_opcode(in_opcode);

    // pushed_q counts only legal words, so illegal beats never use up room.
    assign below_limit = (pushed_q < MEM_LIMIT);
    assign in_ready    = (state_q == ST_LOAD) && !fifo_full && below_limit;
    assign accept      = in_valid && in_ready;
    assign push        = accept && legal;
    assign wr_valid    = !fifo_empty;
    assign pop         = wr_valid && wr_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (packed_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stale storage is masked so wr_data reads zero whenever nothing is offered.
    assign wr_data      = wr_valid ? fifo_rdata : 32'd0;
    assign wr_addr      = addr_q;
    assign word_count   = count_q;
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign err_opcode   = err_op_q;
    assign err_overflow = err_ov_q;
    assign dbg_state    = state_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        pushed_d = pushed_q;
        err_op_d = err_op_q;
        err_ov_d = err_ov_q;

        // Address wraps naturally modulo 2^ADDR_W.
        if (pop) begin
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(1);
        end
        if (push) pushed_d = pushed_q + (ADDR_W+1)'(1);
        if (accept && !legal) err_op_d = 1'b1;
        if ((state_q == ST_LOAD) && in_valid && !below_limit) err_ov_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    addr_d   = '0;
                    count_d  = '0;
                    pushed_d = '0;
                    err_op_d = 1'b0;
                    err_ov_d = 1'b0;
                end
            end
            ST_LOAD: begin
                // A beat accepted in this same cycle is still pushed above.
                if (finish) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // An empty FIFO means no write is outstanding.
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            pushed_q <= '0;
            err_op_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            pushed_q <= pushed_d;
            err_op_q <= err_op_d;
            err_ov_q <= err_ov_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a default instance (depth 4, 256 words) and a small
// instance (4-word limit, 2-bit address) sharing the data inputs and wr_ready.
module tb_instr_encoder;
  import isa_pkg::*;

  localparam int FD = 4;
  localparam int MW = 256;

  logic        clk, rst_n;
  logic        start, finish, start_ov, finish_ov;
  logic        in_valid, wr_ready;
  logic [5:0]  in_opcode;
  logic [2:0]  in_rd, in_r1, in_r2;
  logic [7:0]  in_i1, in_i2;

  logic        in_ready, wr_valid, busy, done, err_opcode, err_overflow;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  word_count;
  logic [1:0]  dbg_state;

  logic        ov_in_ready, ov_wr_valid, ov_busy, ov_done, ov_err_opcode, ov_err_overflow;
  logic [1:0]  ov_wr_addr;
  logic [31:0] ov_wr_data;
  logic [2:0]  ov_word_count;
  logic [1:0]  ov_dbg_state;

  int n_checks = 0;
  int n_errs   = 0;
  bit rand_rdy = 0;

  instr_encoder #(.FIFO_DEPTH(FD), .ADDR_W(8), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_r1(in_r1), .in_r2(in_r2), .in_i1(in_i1), .in_i2(in_i2),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_opcode(err_opcode), .err_overflow(err_overflow),
    .word_count(word_count), .dbg_state(dbg_state));

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(2), .MEM_WORDS(4)) dut_ov (
    .clk(clk), .rst_n(rst_n), .start(start_ov), .finish(finish_ov),
    .in_valid(in_valid), .in_ready(ov_in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_r1(in_r1), .in_r2(in_r2), .in_i1(in_i1), .in_i2(in_i2),
    .wr_valid(ov_wr_valid), .wr_ready(wr_ready), .wr_addr(ov_wr_addr), .wr_data(ov_wr_data),
    .busy(ov_busy), .done(ov_done), .err_opcode(ov_err_opcode), .err_overflow(ov_err_overflow),
    .word_count(ov_word_count), .dbg_state(ov_dbg_state));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word layout computed arithmetically from the field weights.
  function automatic logic [31:0] ref_word(input logic [5:0] op, input logic [2:0] rd, r1, r2,
                                           input logic [7:0] i1, i2);
    return 32'(op) * 32'd67108864 + 32'(rd) * 32'd4194304 + 32'(r1) * 32'd524288 +
           32'(r2) * 32'd65536 + 32'(i1) * 32'd256 + 32'(i2);
  endfunction

  // ---------------- reference model + scoreboard (default instance) ----------------
  logic [31:0] exp_q[$];
  int          m_phase;      // 0 idle, 1 load, 2 drain, 3 done
  int          m_pushed;
  logic [8:0]  m_count;
  logic [7:0]  m_addr;
  bit          m_err_op, m_err_ov;

  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [1:0]  ov_log_addr[$];
  logic [31:0] ov_log_data[$];

  always @(negedge clk) begin
    int sz;
    bit exp_rdy;
    if (!rst_n) begin
      exp_q.delete();
      m_phase = 0; m_pushed = 0; m_count = '0; m_addr = '0; m_err_op = 0; m_err_ov = 0;
      chk("reset_outputs", {in_ready, wr_valid, busy, done, err_opcode, err_overflow,
                            dbg_state, wr_addr, wr_data, word_count}, 64'd0);
    end else begin
      sz = exp_q.size();
      exp_rdy = (m_phase == 1) && (sz < FD) && (m_pushed < MW);
      chk("in_ready", in_ready, exp_rdy);
      chk("wr_valid", wr_valid, sz != 0);
      chk("busy", busy, (m_phase == 1) || (m_phase == 2));
      chk("done", done, m_phase == 3);
      chk("err_opcode", err_opcode, m_err_op);
      chk("err_overflow", err_overflow, m_err_ov);
      chk("word_count", word_count, m_count);
      if (sz != 0) begin
        chk("wr_data", wr_data, exp_q[0]);
        chk("wr_addr", wr_addr, m_addr);
      end
      // effects of the coming rising edge
      if (m_phase == 1 && in_valid && m_pushed >= MW) m_err_ov = 1;
      if (sz != 0 && wr_ready) begin
        log_addr.push_back(wr_addr);
        log_data.push_back(wr_data);
        void'(exp_q.pop_front());
        m_addr++;
        m_count++;
      end
      if (exp_rdy && in_valid) begin
        if (in_opcode == OP_SUMA || in_opcode == OP_RESTA) begin
          exp_q.push_back(ref_word(in_opcode, in_rd, in_r1, in_r2, in_i1, in_i2));
          m_pushed++;
        end else m_err_op = 1;
      end
      case (m_phase)
        0: if (start) begin
             m_phase = 1; m_pushed = 0; m_count = '0; m_addr = '0; m_err_op = 0; m_err_ov = 0;
           end
        1: if (finish) m_phase = 2;
        2: if (sz == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov_wr_valid && wr_ready) begin
      ov_log_addr.push_back(ov_wr_addr);
      ov_log_data.push_back(ov_wr_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_fields(input logic [5:0] op, input logic [2:0] rd, r1, r2,
                            input logic [7:0] i1, i2);
    in_opcode = op; in_rd = rd; in_r1 = r1; in_r2 = r2; in_i1 = i1; in_i2 = i2;
  endtask

  task automatic push_beat(input bit sel, input logic [5:0] op, input logic [2:0] rd, r1, r2,
                           input logic [7:0] i1, i2);
    bit ok;
    ok = 0;
    set_fields(op, rd, r1, r2, i1, i2);
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = sel ? ov_in_ready : in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_ov = 1'b1; else start = 1'b1;
    step();
    start = 1'b0; start_ov = 1'b0;
  endtask

  task automatic pulse_finish(input bit sel);
    if (sel) finish_ov = 1'b1; else finish = 1'b1;
    step();
    finish = 1'b0; finish_ov = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int cyc);
    cyc = -1;
    for (int t = 0; t < 400 && cyc < 0; t++) begin
      @(negedge clk);
      if ((sel ? ov_done : done) === 1'b1) cyc = t;
    end
    step();
    chk("done_seen", cyc >= 0, 1);
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); ov_log_addr.delete(); ov_log_data.delete();
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [5:0]  op;
    logic [2:0]  rd, r1, r2;
    logic [7:0]  i1, i2;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int cyc, n, r, n_legal;
    bit had_bad;
    logic [5:0]  op;
    logic [31:0] held;

    vecs[0] = '{OP_SUMA,  3'd3, 3'd1, 3'd2, 8'h12, 8'h34, 32'h04CA1234};
    vecs[1] = '{OP_RESTA, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 32'h08000000};
    vecs[2] = '{OP_RESTA, 3'd7, 3'd7, 3'd7, 8'hFF, 8'hFF, 32'h09FFFFFF};
    vecs[3] = '{OP_SUMA,  3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 32'h05C00000};
    vecs[4] = '{OP_SUMA,  3'd0, 3'd0, 3'd5, 8'hA5, 8'h5A, 32'h0405A55A};
    vecs[5] = '{OP_SUMA,  3'd0, 3'd7, 3'd0, 8'h00, 8'h00, 32'h04380000};

    rst_n = 1'b0; start = 0; finish = 0; start_ov = 0; finish_ov = 0;
    in_valid = 0; wr_ready = 0;
    set_fields(6'd0, 3'd0, 3'd0, 3'd0, 8'd0, 8'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Basic encode with done timing
    wr_ready = 1'b1;
    clear_logs();
    pulse_start(0);
    push_beat(0, OP_SUMA, 3'd3, 3'd1, 3'd2, 8'h12, 8'h34);
    pulse_finish(0);
    wait_done(0, cyc);
    chk("basic_done_latency", cyc, 1);
    chk("basic_nwrites", log_data.size(), 1);
    if (log_data.size() > 0) begin
      chk("basic_data", log_data[0], 32'h04CA1234);
      chk("basic_addr", log_addr[0], 0);
    end
    chk("basic_count", word_count, 1);

    // Table of encodings
    clear_logs();
    pulse_start(0);
    for (int i = 0; i < 6; i++)
      push_beat(0, vecs[i].op, vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].i1, vecs[i].i2);
    pulse_finish(0);
    wait_done(0, cyc);
    chk("table_nwrites", log_data.size(), 6);
    for (int i = 0; i < 6 && i < log_data.size(); i++) begin
      chk($sformatf("table_data_%0d", i), log_data[i], vecs[i].exp_word);
      chk($sformatf("table_addr_%0d", i), log_addr[i], i);
    end
    chk("table_count", word_count, 6);

    // Illegal opcode dropped
    clear_logs();
    pulse_start(0);
    push_beat(0, 6'b111111, 3'd5, 3'd5, 3'd5, 8'h55, 8'h55);
    push_beat(0, OP_RESTA, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00);
    pulse_finish(0);
    wait_done(0, cyc);
    chk("illegal_nwrites", log_data.size(), 1);
    if (log_data.size() > 0) begin
      chk("illegal_data", log_data[0], 32'h08000000);
      chk("illegal_addr", log_addr[0], 0);
    end
    chk("illegal_err_opcode", err_opcode, 1);

    // Beat accepted in the same cycle as finish is kept
    clear_logs();
    pulse_start(0);
    push_beat(0, OP_SUMA, 3'd1, 3'd1, 3'd1, 8'h01, 8'h01);
    set_fields(OP_RESTA, 3'd2, 3'd2, 3'd2, 8'h02, 8'h02);
    in_valid = 1'b1;
    pulse_finish(0);
    in_valid = 1'b0;
    wait_done(0, cyc);
    chk("finish_beat_nwrites", log_data.size(), 2);
    chk("finish_beat_count", word_count, 2);

    // Backpressure: FIFO fills after 4, head word holds
    clear_logs();
    wr_ready = 1'b0;
    pulse_start(0);
    for (int k = 0; k < 4; k++) push_beat(0, OP_SUMA, 3'd0, 3'd0, 3'd0, 8'h00, 8'(k));
    set_fields(OP_SUMA, 3'd0, 3'd0, 3'd0, 8'h00, 8'd4);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_low", in_ready, 0);
    held = wr_data;
    repeat (3) step();
    @(negedge clk);
    chk("bp_ready_still_low", in_ready, 0);
    chk("bp_data_stable", wr_data, held);
    chk("bp_head_word", wr_data, 32'h04000000);
    step();
    in_valid = 1'b0;
    wr_ready = 1'b1;
    pulse_finish(0);
    wait_done(0, cyc);
    chk("bp_nwrites", log_data.size(), 4);
    for (int k = 0; k < 4 && k < log_data.size(); k++) begin
      chk($sformatf("bp_addr_%0d", k), log_addr[k], k);
      chk($sformatf("bp_data_%0d", k), log_data[k], 32'h04000000 + k);
    end

    // Overflow on the 4-word instance, also wraps the 2-bit address
    clear_logs();
    pulse_start(1);
    chk("ov_busy", ov_busy, 1);
    for (int k = 0; k < 4; k++) push_beat(1, OP_SUMA, 3'd0, 3'd0, 3'd0, 8'h00, 8'h10 + 8'(k));
    @(negedge clk);
    chk("ov_ready_low_at_limit", ov_in_ready, 0);
    step();
    set_fields(OP_RESTA, 3'd1, 3'd1, 3'd1, 8'h11, 8'h11);
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("ov_extra_refused", ov_in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    chk("ov_err_overflow", ov_err_overflow, 1);
    pulse_finish(1);
    wait_done(1, cyc);
    chk("ov_nwrites", ov_log_data.size(), 4);
    for (int k = 0; k < 4 && k < ov_log_data.size(); k++) begin
      chk($sformatf("ov_addr_%0d", k), ov_log_addr[k], k);
      chk($sformatf("ov_data_%0d", k), ov_log_data[k], 32'h04000010 + k);
    end
    chk("ov_count", ov_word_count, 4);
    chk("ov_addr_wrapped", ov_wr_addr, 0);
    chk("ov_err_opcode_clear", ov_err_opcode, 0);
    chk("ov_back_idle", ov_dbg_state, ST_IDLE);
    chk("ov_wr_valid_low", ov_wr_valid, 0);

    // Reset in DRAIN with 2 words buffered
    wr_ready = 1'b0;
    pulse_start(0);
    push_beat(0, OP_SUMA, 3'd1, 3'd2, 3'd3, 8'h44, 8'h55);
    push_beat(0, OP_RESTA, 3'd3, 3'd2, 3'd1, 8'h66, 8'h77);
    pulse_finish(0);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_wr_valid", wr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {in_ready, wr_valid, busy, done, err_opcode, err_overflow,
                              dbg_state, wr_addr, wr_data, word_count}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_no_done_after", done, 0);
    wr_ready = 1'b1;
    clear_logs();
    pulse_start(0);
    push_beat(0, OP_RESTA, 3'd4, 3'd4, 3'd4, 8'h99, 8'h88);
    pulse_finish(0);
    wait_done(0, cyc);
    chk("rst_restart_nwrites", log_data.size(), 1);
    if (log_addr.size() > 0) chk("rst_restart_addr", log_addr[0], 0);

    // Randomized loads with random backpressure, checked by the model
    rand_rdy = 1;
    for (int l = 0; l < 6; l++) begin
      n = $urandom_range(1, 14);
      n_legal = 0;
      had_bad = 0;
      pulse_start(0);
      for (int b = 0; b < n; b++) begin
        r = $urandom_range(0, 5);
        op = (r == 0) ? 6'($urandom_range(0, 63)) : ((r < 3) ? OP_SUMA : OP_RESTA);
        if (op == OP_SUMA || op == OP_RESTA) n_legal++; else had_bad = 1;
        push_beat(0, op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) step();
      end
      pulse_finish(0);
      wait_done(0, cyc);
      chk("rand_count", word_count, n_legal);
      chk("rand_err_opcode", err_opcode, had_bad);
      repeat ($urandom_range(0, 3)) step();
    end
    rand_rdy = 0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-load block that packs decoded instruction fields into 32-bit instruction words and writes them sequentially into instruction memory. It is the write-side counterpart of the control-unit decoder and uses the same field layout, so any word it emits decodes back to the fields it was given. It sits between the host or test loader and the instruction-memory write port. It buffers words in a small FIFO, rejects illegal opcodes, and stops at the memory limit.

## Interface
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and at least 2
- ADDR_W, 8, instruction-memory address width
- MEM_WORDS, 256, maximum words per program load; must be at most 2^ADDR_W
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a program load; honoured only in IDLE
- finish  in  1  one-cycle pulse that ends input; honoured only in LOAD
- in_valid / in_ready  in / out  1 / 1  field-input handshake
- in_opcode  in  6  opcode
- in_rd, in_r1, in_r2  in  3 each  destination and source registers
- in_i1, in_i2  in  8 each  immediates
- wr_valid / wr_ready  out / in  1 / 1  memory-write handshake
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  packed word
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse at the end of a load
- err_opcode  out  1  sticky: an illegal opcode was dropped
- err_overflow  out  1  sticky: input was offered after the MEM_WORDS limit
- word_count  out  ADDR_W+1  number of words written to memory in this load

## Operation
- Packing: wr_data = {opcode[31:26], 1'b0[25], rd[24:22], r1[21:19], r2[18:16], i1[15:8], i2[7:0]}. Bit 25 is always 0.
- Legal opcodes are SUMA 6'b000001 and RESTA 6'b000010.
  - An accepted beat with any other opcode is consumed and dropped; err_opcode is set.
  - Dropped beats do not enter the FIFO and do not count toward the limit.
- States: IDLE, LOAD, DRAIN, DONE.
  - IDLE: in_ready = 0. On start: clear the address, word_count, pushed count, err_opcode and err_overflow, then go to LOAD.
  - LOAD: in_ready = !fifo_full && (pushed < MEM_WORDS). in_ready is combinational from state and counters only, with no path from wr_ready. On finish, go to DRAIN.
  - DRAIN: in_ready = 0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- Output side: wr_valid = !fifo_empty. On wr_valid && wr_ready, pop the FIFO, increment wr_addr and increment word_count.
- Overflow: once pushed == MEM_WORDS, in_ready stays 0. Any cycle in LOAD with in_valid = 1 at the limit sets err_overflow. The FIFO keeps draining.
- A beat accepted in the same cycle that finish arrives is kept.
- start outside IDLE and finish outside LOAD are ignored.

## Timing
- Reset values: state IDLE; in_ready, wr_valid, busy, done, err_opcode, err_overflow = 0; wr_addr, wr_data, word_count = 0; FIFO empty.
- Latency: a beat accepted at edge N drives wr_valid with its word starting at edge N+1.
- wr_addr and wr_data hold stable while wr_valid && !wr_ready.
- Push and pop in the same cycle are both allowed: occupancy is unchanged, and a full FIFO stays full with in_ready = 0 in that cycle.
- wr_addr wraps modulo 2^ADDR_W. This only happens when MEM_WORDS = 2^ADDR_W, after the last word is written.
- Reset asserted mid-load returns every output to its reset value immediately (asynchronously) and discards the FIFO contents. No done pulse is produced.

## Structure
- Package isa_pkg holds:
  - OP_SUMA and OP_RESTA constants
  - field bit-position constants
  - packed struct instr_fields_t (opcode, rd, r1, r2, i1, i2)
  - function pack_instr. The decoder imports the same package.
- Sub-module sync_fifo holds the storage, parameterised on WIDTH=32 and DEPTH=FIFO_DEPTH. It provides full/empty flags and supports simultaneous push and pop.

## Test plan
- Basic encode: start, push SUMA (rd=3, r1=1, r2=2, i1=8'h12, i2=8'h34) with wr_ready=1, then finish. Expect wr_data = 32'h04CA1234 at wr_addr 0, word_count = 1, and a done pulse 2 cycles after finish.
- Illegal opcode: push 6'b111111, then RESTA. Expect only the RESTA word, 32'h08000000 with zero fields, at address 0; err_opcode = 1.
- Backpressure: wr_ready = 0 while pushing. Expect in_ready to fall after 4 accepts and wr_data to stay stable. Release wr_ready: expect addresses 0-3 in push order.
- Overflow: MEM_WORDS = 4, offer 6 beats. Expect exactly 4 writes, in_ready = 0 after the 4th push, and err_overflow = 1.
- Reset mid-DRAIN: assert rst_n = 0 while 2 words are buffered. Expect all outputs 0 and no done pulse. A new start then writes from address 0.
